// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N_CH-input valid/ready mux with round-robin arbitration and a one-entry output register.
// Define RR_MUX_REG_FIXED_PRIO_EN for fixed lowest-index-first arbitration (no priority pointer).
module rr_mux_reg #(
    parameter int  N_CH  = 4,
    parameter int  W     = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_sel
);

    logic [W-1:0]     out_data_d,  out_data_q;
    logic             out_valid_d, out_valid_q;
    logic [SEL_W-1:0] out_sel_d,   out_sel_q;
    logic [SEL_W-1:0] search_base;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] gnt_idx;
    logic [W-1:0]     gnt_data;
    logic             load;

`ifdef RR_MUX_REG_FIXED_PRIO_EN
    assign search_base = '0;
`else
    logic [SEL_W-1:0] ptr_d, ptr_q;
    assign search_base = ptr_q;
`endif

    // Walk the channels in priority order starting at search_base; first valid one wins.
    always_comb begin : arbitrate
        logic found;
        int   slot;
        // NOTE: every signal written here gets a default first, so no path can leave one
        // unassigned and infer a latch.
        grant    = '0;
        gnt_idx  = '0;
        gnt_data = '0;
        found    = 1'b0;
        slot     = 0;
        for (int k = 0; k < N_CH; k++) begin
            slot = int'(search_base) + k;
            if (slot >= N_CH) begin
                slot = slot - N_CH;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (!found && in_valid[i] && (i == slot)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gnt_idx  = SEL_W'(i);
                    gnt_data = in_data[i*W +: W];
                end
            end
        end
    end

    always_comb begin : next_state
        load        = !out_valid_q || out_ready;
        in_ready    = (load && !rst) ? grant : '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifndef RR_MUX_REG_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        // A free or draining register takes the granted word; with nothing granted it empties.
        if (load) begin
            out_valid_d = |grant;
            if (|grant) begin
                out_data_d = gnt_data;
                out_sel_d  = gnt_idx;
`ifndef RR_MUX_REG_FIXED_PRIO_EN
                ptr_d      = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every flop samples the pre-edge value of the others.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifndef RR_MUX_REG_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifndef RR_MUX_REG_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: scoreboard bench for rr_mux_reg (4x4 directed, plus 2x8 and 5x1 randomised instances).
module tb_rr_mux_reg;

    typedef struct {
        logic [7:0] data;
        int         sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Main instance: N_CH=4, W=4.
    logic [15:0] in_data  = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_sel;
    exp_t        q_main[$];

    // Sweep instance: N_CH=2, W=8.
    logic [15:0] d2 = '0;
    logic [1:0]  v2 = '0;
    logic [1:0]  rdy2;
    logic [7:0]  o2;
    logic        o2v;
    logic        o2r = 1'b0;
    logic [0:0]  s2;
    exp_t        q2[$];

    // Sweep instance: N_CH=5, W=1.
    logic [4:0]  d5 = '0;
    logic [4:0]  v5 = '0;
    logic [4:0]  rdy5;
    logic [0:0]  o5;
    logic        o5v;
    logic        o5r = 1'b0;
    logic [2:0]  s5;
    exp_t        q5[$];
    int          wraps5 = 0;

    rr_mux_reg #(.N_CH(4), .W(4)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
    );

    rr_mux_reg #(.N_CH(2), .W(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
        .out_data(o2), .out_valid(o2v), .out_ready(o2r), .out_sel(s2)
    );

    rr_mux_reg #(.N_CH(5), .W(1)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(d5), .in_valid(v5), .in_ready(rdy5),
        .out_data(o5), .out_valid(o5v), .out_ready(o5r), .out_sel(s5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [15:0] v, input int ptr, input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            c = (ptr + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop one expected word for every word the consumer takes.
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q_main.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL main_unexpected_word: got %0h sel %0d, expected none", out_data, out_sel);
            end else begin
                e = q_main.pop_front();
                check("main_data", 32'(out_data), 32'(e.data));
                check("main_sel", 32'(out_sel), 32'(e.sel));
            end
        end
    end

    always @(negedge clk) begin : mon_2
        exp_t e;
        if (!rst && o2v && o2r) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL n2_unexpected_word: got %0h sel %0d, expected none", o2, s2);
            end else begin
                e = q2.pop_front();
                check("n2_data", 32'(o2), 32'(e.data));
                check("n2_sel", 32'(s2), 32'(e.sel));
            end
        end
    end

    always @(negedge clk) begin : mon_5
        exp_t e;
        if (!rst && o5v && o5r) begin
            if (q5.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL n5_unexpected_word: got %0h sel %0d, expected none", o5, s5);
            end else begin
                e = q5.pop_front();
                check("n5_data", 32'(o5), 32'(e.data));
                check("n5_sel", 32'(s5), 32'(e.sel));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main_seq
        // 1. Reset for two edges with every channel requesting.
        rst       = 1'b1;
        in_valid  = 4'hf;
        in_data   = {4'hd, 4'hc, 4'hb, 4'ha};
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;

        // 2. Streaming: a,b,c,d,a,b back to back.
        q_main.push_back('{data: 8'ha, sel: 0});
        q_main.push_back('{data: 8'hb, sel: 1});
        q_main.push_back('{data: 8'hc, sel: 2});
        q_main.push_back('{data: 8'hd, sel: 3});
        q_main.push_back('{data: 8'ha, sel: 0});
        q_main.push_back('{data: 8'hb, sel: 1});
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("first_grant_ch0", 32'(in_ready), 32'h1);
        repeat (6) @(posedge clk);
        #1;

        // 3. Backpressure while 'hb is held.
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'hb);
            check("bp_out_sel", 32'(out_sel), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        q_main.push_back('{data: 8'hc, sel: 2});
        @(negedge clk);
        check("bp_release_grant_ch2", 32'(in_ready), 32'h4);
        tick();
        in_valid = 4'h0;
        tick();
        @(negedge clk);
        check("idle_valid_drops", 32'(out_valid), 32'd0);

        // 4. Sparse traffic: ch3 then ch1, pointer wraps to 0.
        tick();
        in_data[15:12] = 4'h7;
        in_valid       = 4'b1000;
        q_main.push_back('{data: 8'h7, sel: 3});
        @(negedge clk);
        check("sparse_grant_ch3", 32'(in_ready), 32'h8);
        tick();
        in_data[7:4] = 4'h3;
        in_valid     = 4'b0010;
        q_main.push_back('{data: 8'h3, sel: 1});
        @(negedge clk);
        check("sparse_grant_ch1", 32'(in_ready), 32'h2);
        tick();
        in_valid = 4'h0;
        tick();
        @(negedge clk);
        check("sparse_idle_valid", 32'(out_valid), 32'd0);

        // 5. Reset while 'hc is held under backpressure; the word is dropped.
        tick();
        in_data   = {4'hd, 4'hc, 4'hb, 4'ha};
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        tick();
        in_valid = 4'hf;
        rst      = 1'b1;
        @(negedge clk);
        check("midrst_held_data", 32'(out_data), 32'hc);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst       = 1'b0;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        q_main.push_back('{data: 8'hb, sel: 1});
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_sel", 32'(out_sel), 32'd0);
        check("midrst_lowest_grant", 32'(in_ready), 32'h2);
        tick();
        in_valid = 4'h0;
        repeat (2) tick();

        // 6. Parameter sweep against a reference queue model.
        fork
            begin : sweep2
                int g;
                bit ld;
                int ptr;
                bit mv;
                ptr = 0;
                mv  = 1'b0;
                for (int it = 0; it < 300; it++) begin
                    for (int i = 0; i < 2; i++) begin
                        if (!v2[i] && $urandom_range(0, 2) != 0) begin
                            v2[i]        = 1'b1;
                            d2[i*8 +: 8] = 8'($urandom);
                        end
                    end
                    o2r = ($urandom_range(0, 3) != 0);
                    g   = rr_pick(16'(v2), ptr, 2);
                    ld  = !mv || o2r;
                    @(negedge clk);
                    check("n2_in_ready", 32'(rdy2), (ld && g >= 0) ? (32'd1 << g) : 32'd0);
                    @(posedge clk);
                    if (ld) begin
                        if (g >= 0) begin
                            q2.push_back('{data: d2[g*8 +: 8], sel: g});
                            ptr = (g + 1) % 2;
                            mv  = 1'b1;
                        end else begin
                            mv = 1'b0;
                        end
                    end
                    #1;
                    if (ld && g >= 0) v2[g] = 1'b0;
                end
                v2  = '0;
                o2r = 1'b1;
            end
            begin : sweep5
                int g;
                bit ld;
                int ptr;
                bit mv;
                int last;
                ptr  = 0;
                mv   = 1'b0;
                last = -1;
                for (int it = 0; it < 300; it++) begin
                    for (int i = 0; i < 5; i++) begin
                        if (!v5[i] && $urandom_range(0, 2) != 0) begin
                            v5[i] = 1'b1;
                            d5[i] = 1'($urandom);
                        end
                    end
                    o5r = ($urandom_range(0, 3) != 0);
                    g   = rr_pick(16'(v5), ptr, 5);
                    ld  = !mv || o5r;
                    @(negedge clk);
                    check("n5_in_ready", 32'(rdy5), (ld && g >= 0) ? (32'd1 << g) : 32'd0);
                    @(posedge clk);
                    if (ld) begin
                        if (g >= 0) begin
                            q5.push_back('{data: 8'(d5[g]), sel: g});
                            if (last == 4 && g == 0) wraps5++;
                            last = g;
                            ptr  = (g + 1) % 5;
                            mv   = 1'b1;
                        end else begin
                            mv = 1'b0;
                        end
                    end
                    #1;
                    if (ld && g >= 0) v5[g] = 1'b0;
                end
                v5  = '0;
                o5r = 1'b1;
            end
        join

        // Drain: every predicted word must have been delivered.
        repeat (10) tick();
        check("main_queue_drained", 32'(q_main.size()), 32'd0);
        check("n2_queue_drained", 32'(q2.size()), 32'd0);
        check("n5_queue_drained", 32'(q5.size()), 32'd0);
        check("n5_wrap_4_to_0_seen", 32'(wraps5 > 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
